// File: rtl/dekoder_pkg.sv
// Shared types, blanking constants and the BCD-to-7-segment table
// used by the dekoder_scan_mux display driver.
package dekoder_pkg;

   typedef logic [6:0] seg7_t;   // {g,f,e,d,c,b,a}, active-high
   typedef logic [3:0] bcd_t;

   localparam seg7_t SEG_BLANK = 7'h00;
   localparam bcd_t  BCD_BLANK = 4'hF;

   // Codes 0-9 map to digit glyphs; A-F are treated as blank.
   function automatic seg7_t seg7_lut(input bcd_t code);
      seg7_t seg;
      case (code)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/dekoder_bcd7.sv
// Combinational single-digit BCD to 7-segment decoder (codes A-F blank).
module dekoder_bcd7
   import dekoder_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = seg7_lut(code);

endmodule

// File: rtl/dekoder_scan_mux.sv
// N-digit time-multiplexed BCD-to-7-segment driver with a valid/ready
// load port, frame-synchronous double buffering and leading-zero blanking.
// Optional feature: define DEKODER_BLINK_EN to add blink_mask and the
// frame-counted blink phase.
module dekoder_scan_mux
   import dekoder_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int SEG_ACT_LOW  = 0,
   parameter int DIG_ACT_LOW  = 0,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*N_DIGITS-1:0]   load_bcd,
   input  logic [N_DIGITS-1:0]     load_dp,
   input  logic                    lzb_en,
`ifdef DEKODER_BLINK_EN
   input  logic [N_DIGITS-1:0]     blink_mask,
`endif
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [N_DIGITS-1:0]     dig_o,
   output logic                    frame_o
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int PRE_W = $clog2(SCAN_DIV);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

   // Inactive output levels; XOR with these applies the polarity.
   localparam seg7_t                SEG_OFF = {7{SEG_ACT_LOW != 0}};
   localparam logic                 DP_OFF  = (SEG_ACT_LOW != 0);
   localparam logic [N_DIGITS-1:0]  DIG_OFF = {N_DIGITS{DIG_ACT_LOW != 0}};

   logic [PRE_W-1:0]     presc;
   logic [IDX_W-1:0]     idx;
   logic                 tick;
   logic                 boundary;
   logic                 accept;

   bcd_t                 pend_bcd [N_DIGITS];
   logic [N_DIGITS-1:0]  pend_dp;
   logic                 pend_full;
   bcd_t                 disp_bcd [N_DIGITS];
   logic [N_DIGITS-1:0]  disp_dp;

   logic [N_DIGITS-1:0]  lzb_blank;
   logic                 all_above;
   logic                 blink_blank;
   bcd_t                 cur_code;
   seg7_t                cur_seg;
   seg7_t                seg_next;
   logic                 dp_next;
   logic [N_DIGITS-1:0]  dig_next;

   assign tick       = (presc == PRE_MAX);
   assign boundary   = tick && (idx == IDX_MAX);
   assign load_ready = ~pend_full;
   assign accept     = load_valid && load_ready;

   // Prescaler, digit index and frame pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc   <= '0;
         idx     <= '0;
         frame_o <= 1'b0;
      end else begin
         frame_o <= boundary;
         if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Pending/display double buffer; swap only at the frame boundary.
   // accept requires an empty pending buffer, so the swap and a capture
   // can never both be due in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_full <= 1'b0;
         pend_dp   <= '0;
         disp_dp   <= '0;
         for (int unsigned k = 0; k < N_DIGITS; k++) begin
            pend_bcd[k] <= BCD_BLANK;
            disp_bcd[k] <= BCD_BLANK;
         end
      end else if (boundary && pend_full) begin
         disp_bcd  <= pend_bcd;
         disp_dp   <= pend_dp;
         pend_full <= 1'b0;
      end else if (accept) begin
         for (int unsigned k = 0; k < N_DIGITS; k++)
            pend_bcd[k] <= load_bcd[4*k +: 4];
         pend_dp   <= load_dp;
         pend_full <= 1'b1;
      end
   end

   // Leading-zero mask: walk from the top digit down while every digit
   // seen so far is zero or a blank code; digit 0 is always shown.
   always_comb begin
      int unsigned k;
      lzb_blank = '0;
      all_above = 1'b1;
      for (int unsigned j = 0; j < N_DIGITS; j++) begin
         k = N_DIGITS - 1 - j;
         if (k != 0 && lzb_en && disp_bcd[k] == 4'd0 && all_above)
            lzb_blank[k] = 1'b1;
         all_above = all_above && (disp_bcd[k] == 4'd0 || disp_bcd[k] > 4'd9);
      end
   end

`ifdef DEKODER_BLINK_EN
   localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BF_W-1:0] BF_MAX = BF_W'(BLINK_FRAMES - 1);

   logic [BF_W-1:0] frame_cnt;
   logic            phase;

   // Frame counter; blink phase flips each time it wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         phase     <= 1'b0;
      end else if (boundary) begin
         if (frame_cnt == BF_MAX) begin
            frame_cnt <= '0;
            phase     <= ~phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   assign blink_blank = phase && blink_mask[idx];
`else
   assign blink_blank = 1'b0;
`endif

   assign cur_code = disp_bcd[idx];

   dekoder_bcd7 u_bcd7 (
      .code (cur_code),
      .seg  (cur_seg)
   );

   // Next output values for the currently scanned digit.
   always_comb begin
      seg_next      = (lzb_blank[idx] || blink_blank) ? SEG_BLANK : cur_seg;
      dp_next       = disp_dp[idx] && !blink_blank;
      dig_next      = '0;
      dig_next[idx] = 1'b1;
   end

   // Output flops with polarity applied.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_o <= SEG_OFF;
         dp_o  <= DP_OFF;
         dig_o <= DIG_OFF;
      end else begin
         seg_o <= seg_next ^ SEG_OFF;
         dp_o  <= dp_next ^ DP_OFF;
         dig_o <= dig_next ^ DIG_OFF;
      end
   end

endmodule

// File: tb/tb_dekoder_scan_mux.sv
// Self-checking bench for dekoder_scan_mux (N_DIGITS=4, SCAN_DIV=4).
// Blink checks are compiled only when DEKODER_BLINK_EN is defined.
module tb_dekoder_scan_mux;

   localparam int N = 4;
   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [15:0] load_bcd = '0;
   logic [3:0]  load_dp = '0;
   logic        lzb_en = 1'b0;
`ifdef DEKODER_BLINK_EN
   logic [3:0]  blink_mask = '0;
`endif
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  dig_o;
   logic        frame_o;

   int unsigned total = 0;
   int unsigned passed = 0;
   logic [6:0]  tbl [16];

   dekoder_scan_mux #(
      .N_DIGITS     (N),
      .SCAN_DIV     (S),
      .SEG_ACT_LOW  (0),
      .DIG_ACT_LOW  (0),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_bcd   (load_bcd),
      .load_dp    (load_dp),
      .lzb_en     (lzb_en),
`ifdef DEKODER_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .seg_o      (seg_o),
      .dp_o       (dp_o),
      .dig_o      (dig_o),
      .frame_o    (frame_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Expected glyph of digit d of word w, leading-zero rule applied.
   function automatic logic [6:0] exp_seg(input logic [15:0] w, input logic lzb, input int d);
      logic [3:0] c;
      bit higher_empty;
      higher_empty = 1'b1;
      c = w[4*d +: 4];
      for (int j = d + 1; j < N; j++)
         if (w[4*j +: 4] inside {[4'd1:4'd9]}) higher_empty = 1'b0;
      if (d > 0 && lzb && c == 4'd0 && higher_empty) return 7'h00;
      return (c <= 4'd9) ? tbl[c] : 7'h00;
   endfunction

   // Advance to the negedge where frame_o is high (bounded).
   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (frame_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_frame"}, 32'(frame_o), 32'd1);
   endtask

   // Called at the frame_o negedge (or just after the accept edge that
   // follows it); checks each digit slot well inside the slot.
   task automatic check_frame(input logic [15:0] w, input logic [3:0] dp, input logic lzb,
                              input logic [3:0] bmask, input string tag);
      logic [6:0] es;
      logic       ed;
      repeat (2) @(negedge clk);
      for (int d = 0; d < N; d++) begin
         es = bmask[d] ? 7'h00 : exp_seg(w, lzb, d);
         ed = bmask[d] ? 1'b0 : dp[d];
         chk($sformatf("%s_d%0d_seg", tag, d), 32'(seg_o), 32'(es));
         chk($sformatf("%s_d%0d_dp", tag, d), 32'(dp_o), 32'(ed));
         chk($sformatf("%s_d%0d_dig", tag, d), 32'(dig_o), 32'(4'b0001 << d));
         if (d < N - 1) repeat (S) @(negedge clk);
      end
   endtask

   task automatic load(input logic [15:0] w, input logic [3:0] dp, input string tag);
      int n;
      n = 0;
      while (load_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(load_ready), 32'd1);
      load_bcd   = w;
      load_dp    = dp;
      load_valid = 1'b1;
      @(posedge clk);
      #1 load_valid = 1'b0;
      chk({tag, "_full"}, 32'(load_ready), 32'd0);
   endtask

   initial begin
      logic [15:0] w;
      logic [3:0]  dp;
      logic        lz;
      int          n;

      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

      // Reset held for three edges.
      repeat (3) @(negedge clk);
      chk("rst_seg", 32'(seg_o), 32'h00);
      chk("rst_dp", 32'(dp_o), 32'd0);
      chk("rst_dig", 32'(dig_o), 32'd0);
      chk("rst_frame", 32'(frame_o), 32'd0);
      chk("rst_ready", 32'(load_ready), 32'd1);
      rst_n = 1'b1;

      // Basic load.
      wait_frame("t2a");
      load(16'h1234, 4'b0001, "t2");
      wait_frame("t2b");
      check_frame(16'h1234, 4'b0001, 1'b0, 4'b0000, "t2");

      // Every code through digit 0.
      for (int c = 0; c < 16; c++) begin
         w = 16'h9870 | 16'(c);
         wait_frame("t3a");
         load(w, 4'b0000, "t3");
         wait_frame("t3b");
         check_frame(w, 4'b0000, 1'b0, 4'b0000, $sformatf("t3_c%0d", c));
      end

      // Leading-zero blanking on and off.
      lzb_en = 1'b1;
      wait_frame("t4a");
      load(16'h0050, 4'b0000, "t4");
      wait_frame("t4b");
      check_frame(16'h0050, 4'b0000, 1'b1, 4'b0000, "t4_lzb");
      lzb_en = 1'b0;
      wait_frame("t4c");
      check_frame(16'h0050, 4'b0000, 1'b0, 4'b0000, "t4_nolzb");

      // Randomized loads against the model.
      for (int i = 0; i < 8; i++) begin
         w  = 16'($urandom);
         dp = 4'($urandom);
         lz = 1'($urandom_range(0, 1));
         for (int k = 0; k < N; k++)
            if ($urandom_range(0, 2) == 0) w[4*k +: 4] = 4'd0;
         lzb_en = lz;
         wait_frame("rnd_a");
         load(w, dp, "rnd");
         wait_frame("rnd_b");
         check_frame(w, dp, lz, 4'b0000, $sformatf("rnd%0d", i));
      end
      lzb_en = 1'b0;

      // Back-to-back loads: second waits for the boundary.
      wait_frame("t5a");
      load(16'h1111, 4'b0000, "t5_first");
      @(negedge clk);
      load_bcd   = 16'h2222;
      load_dp    = 4'b1010;
      load_valid = 1'b1;
      chk("t5_blocked", 32'(load_ready), 32'd0);
      n = 0;
      while (load_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t5_ready_at_frame", 32'(frame_o), 32'd1);
      @(posedge clk);
      #1 load_valid = 1'b0;
      check_frame(16'h1111, 4'b0000, 1'b0, 4'b0000, "t5_f1");
      wait_frame("t5b");
      check_frame(16'h2222, 4'b1010, 1'b0, 4'b0000, "t5_f2");

      // Mid-frame reset with pending data.
      wait_frame("t6a");
      load(16'h8888, 4'b1111, "t6");
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_seg", 32'(seg_o), 32'h00);
      chk("t6_dp", 32'(dp_o), 32'd0);
      chk("t6_dig", 32'(dig_o), 32'd0);
      chk("t6_frame", 32'(frame_o), 32'd0);
      chk("t6_ready", 32'(load_ready), 32'd1);
      rst_n = 1'b1;
      wait_frame("t6b");
      check_frame(16'hFFFF, 4'b0000, 1'b0, 4'b0000, "t6_f1");
      wait_frame("t6c");
      check_frame(16'hFFFF, 4'b0000, 1'b0, 4'b0000, "t6_f2");

`ifdef DEKODER_BLINK_EN
      // Blink: phase flips every 2 boundaries counted from reset.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      blink_mask = 4'b0001;
      wait_frame("bl_a");
      load(16'h1234, 4'b0001, "bl");
      for (int b = 2; b < 8; b++) begin
         wait_frame("bl_b");
         check_frame(16'h1234, 4'b0001, 1'b0, ((b / 2) % 2 == 1) ? 4'b0001 : 4'b0000,
                     $sformatf("blink_b%0d", b));
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
